// File: rtl/oled_pkg.sv
// oled_pkg: shared panel geometry, field widths and encodings for the SSD1331 SPI capture.
package oled_pkg;
  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_NPIX   = OLED_WIDTH * OLED_HEIGHT;
  localparam int PIX_IDX_W   = 13;
  localparam int X_W         = 7;
  localparam int Y_W         = 6;
  localparam logic DC_CMD    = 1'b0;
  localparam logic DC_DATA   = 1'b1;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
endpackage

// File: rtl/oled_spi_sync.sv
// oled_spi_sync: synchronizes the SPI lines and flags sclk rising edges, with all outputs aligned.
module oled_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sdin,
  input  logic sclk,
  input  logic d_cn,
  input  logic resn,
  output logic cs_s,
  output logic sdin_s,
  output logic d_cn_s,
  output logic resn_s,
  output logic sclk_rise
);
  // bit order {resn, d_cn, sclk, sdin, cs}; reset value reads as an idle, unreset bus
  localparam logic [4:0] IDLE_V = 5'b10001;
  logic [STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0] out_q, out_d;
  logic rise_q, rise_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], resn, d_cn, sclk, sdin, cs};
    out_d  = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1][2] & ~out_q[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{IDLE_V}};
      out_q  <= IDLE_V;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      out_q  <= out_d;
      rise_q <= rise_d;
    end
  end
  assign cs_s      = out_q[0];
  assign sdin_s    = out_q[1];
  assign d_cn_s    = out_q[3];
  assign resn_s    = out_q[4];
  assign sclk_rise = rise_q;
endmodule

// File: rtl/oled_spi_capture.sv
// oled_spi_capture: rebuilds SSD1331 command bytes and indexed RGB565 pixels from the tapped SPI stream.
module oled_spi_capture
  import oled_pkg::*;
#(
  parameter int WIDTH       = OLED_WIDTH,
  parameter int HEIGHT      = OLED_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sdin,
  input  logic                 sclk,
  input  logic                 d_cn,
  input  logic                 resn,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_byte,
  output logic                 pix_valid,
  output logic [15:0]          pix_data,
  output logic [PIX_IDX_W-1:0] pix_index,
  output logic [X_W-1:0]       pix_x,
  output logic [Y_W-1:0]       pix_y,
  output logic                 frame_done,
  output logic [7:0]           frame_count,
  output logic                 err_partial
);
  logic cs_s, sdin_s, d_cn_s, resn_s, sclk_rise;
  oled_spi_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn), .resn(resn),
    .cs_s(cs_s), .sdin_s(sdin_s), .d_cn_s(d_cn_s), .resn_s(resn_s), .sclk_rise(sclk_rise)
  );
  state_e state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic phase_q, phase_d;
  logic [7:0] hi_q, hi_d;
  logic [X_W-1:0] x_q, x_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0] y_q, y_d, pix_y_q, pix_y_d;
  logic [PIX_IDX_W-1:0] idx_q, idx_d, pix_index_q, pix_index_d;
  logic cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic frame_done_q, frame_done_d, err_partial_q, err_partial_d;
  logic [7:0] cmd_byte_q, cmd_byte_d, frame_count_q, frame_count_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [7:0] byte_v;
  logic last_x, last_y, last_px;
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    x_d           = x_q;
    y_d           = y_q;
    idx_d         = idx_q;
    cmd_valid_d   = 1'b0;
    cmd_byte_d    = cmd_byte_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_index_d   = pix_index_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_partial_d = 1'b0;
    byte_v        = {shift_q, sdin_s};
    last_x        = x_q == X_W'(WIDTH - 1);
    last_y        = y_q == Y_W'(HEIGHT - 1);
    last_px       = idx_q == PIX_IDX_W'(WIDTH * HEIGHT - 1);
    if (state_q == ST_IDLE) begin
      state_d = cs_s ? ST_IDLE : ST_SHIFT;
    end else if (cs_s) begin
      state_d       = ST_IDLE;
      bit_cnt_d     = 3'd0;
      err_partial_d = bit_cnt_q != 3'd0;
    end else if (sclk_rise) begin
      shift_d   = byte_v[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        if (d_cn_s == DC_CMD) begin
          // commands only precede a full-screen write, so restart the raster here
          cmd_valid_d = 1'b1;
          cmd_byte_d  = byte_v;
          phase_d     = 1'b0;
          x_d         = '0;
          y_d         = '0;
          idx_d       = '0;
        end else if (!phase_q) begin
          hi_d    = byte_v;
          phase_d = 1'b1;
        end else begin
          phase_d       = 1'b0;
          pix_valid_d   = 1'b1;
          pix_data_d    = {hi_q, byte_v};
          pix_index_d   = idx_q;
          pix_x_d       = x_q;
          pix_y_d       = y_q;
          frame_done_d  = last_px;
          frame_count_d = frame_count_q + (last_px ? 8'd1 : 8'd0);
          x_d           = last_x ? '0 : x_q + X_W'(1);
          y_d           = last_x ? (last_y ? '0 : y_q + Y_W'(1)) : y_q;
          idx_d         = last_px ? '0 : idx_q + PIX_IDX_W'(1);
        end
      end
    end
    if (!resn_s) begin
      state_d       = ST_IDLE;
      shift_d       = '0;
      bit_cnt_d     = '0;
      phase_d       = 1'b0;
      hi_d          = '0;
      x_d           = '0;
      y_d           = '0;
      idx_d         = '0;
      cmd_valid_d   = 1'b0;
      cmd_byte_d    = '0;
      pix_valid_d   = 1'b0;
      pix_data_d    = '0;
      pix_index_d   = '0;
      pix_x_d       = '0;
      pix_y_d       = '0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      err_partial_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      idx_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_byte_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_index_q   <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      x_q           <= x_d;
      y_q           <= y_d;
      idx_q         <= idx_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_byte_q    <= cmd_byte_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_index_q   <= pix_index_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_partial_q <= err_partial_d;
    end
  end
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_index   = pix_index_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_partial = err_partial_q;
endmodule

// File: tb/tb_oled_spi_capture.sv
// tb_oled_spi_capture: directed checks on a full-size capture and an 8x4 one sharing the same SPI stream.
module tb_oled_spi_capture;
  logic clk = 1'b0;
  logic reset, cs, sdin, sclk, d_cn, resn;
  logic b_cmd_valid, b_pix_valid, b_frame_done, b_err_partial;
  logic [7:0] b_cmd_byte, b_frame_count;
  logic [15:0] b_pix_data;
  logic [12:0] b_pix_index;
  logic [6:0] b_pix_x;
  logic [5:0] b_pix_y;
  logic s_cmd_valid, s_pix_valid, s_frame_done, s_err_partial;
  logic [7:0] s_cmd_byte, s_frame_count;
  logic [15:0] s_pix_data;
  logic [12:0] s_pix_index;
  logic [6:0] s_pix_x;
  logic [5:0] s_pix_y;
  int checks = 0, errors = 0;
  int b_cmd_n = 0, b_err_n = 0, b_fd_n = 0, s_err_n = 0, s_fd_n = 0, s_fd_lone = 0;
  logic [41:0] bq[$], sq[$];
  int base_b, base_s;
  logic [7:0] v;
  always #5 clk = ~clk;
  oled_spi_capture dut_b (
    .clk(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn), .resn(resn),
    .cmd_valid(b_cmd_valid), .cmd_byte(b_cmd_byte), .pix_valid(b_pix_valid), .pix_data(b_pix_data),
    .pix_index(b_pix_index), .pix_x(b_pix_x), .pix_y(b_pix_y), .frame_done(b_frame_done),
    .frame_count(b_frame_count), .err_partial(b_err_partial)
  );
  oled_spi_capture #(.WIDTH(8), .HEIGHT(4)) dut_s (
    .clk(clk), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .d_cn(d_cn), .resn(resn),
    .cmd_valid(s_cmd_valid), .cmd_byte(s_cmd_byte), .pix_valid(s_pix_valid), .pix_data(s_pix_data),
    .pix_index(s_pix_index), .pix_x(s_pix_x), .pix_y(s_pix_y), .frame_done(s_frame_done),
    .frame_count(s_frame_count), .err_partial(s_err_partial)
  );
  always @(negedge clk) begin
    if (b_pix_valid) bq.push_back({b_pix_data, b_pix_index, b_pix_x, b_pix_y});
    if (s_pix_valid) sq.push_back({s_pix_data, s_pix_index, s_pix_x, s_pix_y});
    if (b_cmd_valid) b_cmd_n++;
    if (b_err_partial) b_err_n++;
    if (s_err_partial) s_err_n++;
    if (b_frame_done) b_fd_n++;
    if (s_frame_done) s_fd_n++;
    if (s_frame_done && !s_pix_valid) s_fd_lone++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input int n, input int hp);
    for (int i = 0; i < n; i++) begin
      sdin = b[7-i];
      tick(hp);
      sclk = 1'b1;
      tick(hp);
      sclk = 1'b0;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8, 2);
  endtask
  initial begin
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; sdin = 1'b0; d_cn = 1'b0; resn = 1'b1;
    tick(5);
    chk("rst_cmd_byte", b_cmd_byte, 0);
    chk("rst_pix_data", b_pix_data, 0);
    chk("rst_frame_count", b_frame_count, 0);
    chk("rst_strobes", {b_cmd_valid, b_pix_valid, b_frame_done, b_err_partial}, 0);
    reset = 1'b0;
    tick(4);
    cs = 1'b0; d_cn = 1'b0;
    tick(4);
    send_bits(8'hAF, 7, 8);
    sdin = 1'b1;
    tick(8);
    sclk = 1'b1;
    tick(3);
    chk("lat_early", b_cmd_valid, 0);
    tick(1);
    chk("lat_strobe", b_cmd_valid, 1);
    chk("lat_byte", b_cmd_byte, 8'hAF);
    tick(1);
    chk("lat_one_cycle", b_cmd_valid, 0);
    tick(4);
    sclk = 1'b0;
    tick(8);
    chk("cmd_count", b_cmd_n, 1);
    chk("cmd_no_pix", bq.size(), 0);
    chk("s_cmd_byte", s_cmd_byte, 8'hAF);
    d_cn = 1'b1;
    send_byte(8'hF8);
    tick(6);
    chk("hi_no_strobe", bq.size(), 0);
    send_byte(8'h1F);
    tick(6);
    chk("px_count", bq.size(), 1);
    chk("px0", bq[0], {16'hF81F, 13'd0, 7'd0, 6'd0});
    chk("px0_hold", b_pix_data, 16'hF81F);
    d_cn = 1'b0;
    send_byte(8'hA0);
    tick(6);
    chk("cmd2_count", b_cmd_n, 2);
    base_b = bq.size();
    base_s = sq.size();
    d_cn = 1'b1;
    for (int k = 0; k < 97; k++) begin
      v = 8'(k);
      send_byte(v);
      send_byte(~v);
    end
    tick(6);
    chk("row_count", bq.size() - base_b, 97);
    chk("row_x95", bq[base_b+95], {16'h5FA0, 13'd95, 7'd95, 6'd0});
    chk("row_wrap", bq[base_b+96], {16'h609F, 13'd96, 7'd0, 6'd1});
    chk("s_last_px", sq[base_s+95], {16'h5FA0, 13'd31, 7'd7, 6'd3});
    chk("s_idx_wrap", sq[base_s+96], {16'h609F, 13'd0, 7'd0, 6'd0});
    chk("s_frames", s_fd_n, 3);
    chk("s_frame_count", s_frame_count, 3);
    chk("s_fd_with_pix", s_fd_lone, 0);
    chk("b_no_frame", b_fd_n, 0);
    d_cn = 1'b0;
    send_bits(8'hFF, 5, 2);
    tick(2);
    cs = 1'b1;
    tick(6);
    chk("abort_err_b", b_err_n, 1);
    chk("abort_err_s", s_err_n, 1);
    chk("abort_no_cmd", b_cmd_n, 2);
    chk("abort_no_pix", bq.size(), 98);
    send_byte(8'h55);
    tick(6);
    chk("cs_high_no_cmd", b_cmd_n, 2);
    chk("cs_high_no_err", b_err_n, 1);
    cs = 1'b0;
    tick(4);
    send_byte(8'h3C);
    tick(6);
    chk("after_abort_byte", b_cmd_byte, 8'h3C);
    chk("after_abort_count", b_cmd_n, 3);
    d_cn = 1'b1;
    send_byte(8'h99);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(6);
    chk("midrst_frame_count", s_frame_count, 0);
    chk("midrst_cmd_byte", b_cmd_byte, 0);
    base_b = bq.size();
    send_byte(8'h12);
    send_byte(8'h34);
    tick(6);
    chk("midrst_px_count", bq.size() - base_b, 1);
    chk("midrst_px", bq[base_b], {16'h1234, 13'd0, 7'd0, 6'd0});
    for (int k = 1; k < 34; k++) begin
      v = 8'(k);
      send_byte(v);
      send_byte(v);
    end
    tick(6);
    chk("pre_resn_frames", s_frame_count, 1);
    chk("pre_resn_index", b_pix_index, 33);
    resn = 1'b0;
    tick(6);
    chk("resn_index", b_pix_index, 0);
    chk("resn_data", b_pix_data, 0);
    chk("resn_keeps_frames", s_frame_count, 1);
    resn = 1'b1;
    tick(6);
    send_byte(8'hAB);
    send_byte(8'hCD);
    tick(6);
    chk("resn_next_px", bq[bq.size()-1], {16'hABCD, 13'd0, 7'd0, 6'd0});
    chk("resn_frames_after", s_frame_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
